bht_update_ctrl: RTL and testbench
==================================

Name: bht_update_ctrl

Overview:
- Arbitrates the single-port branch history table between fetch-stage lookups and execute-stage resolved-branch updates.
- Lookups always win the port. Updates are buffered in a small FIFO and retired as read-modify-write sequences that apply 2-bit saturating counter rules.
- Sits between the fetch/decode pipeline and the BHT storage array. It owns all table writes.

Parameters:
- IDX_W, 3, table index width (8 entries)
- QDEPTH, 4, update FIFO depth (power of two)
- TGT_W, 32, PC/target width
- STARVE_LIM, 8, consecutive blocked cycles before a forced update (only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- lk_req  in  1  fetch lookup request this cycle
- lk_index  in  IDX_W  lookup index
- lk_gnt  out  1  lookup owns the table port this cycle
- upd_valid  in  1  resolved-branch update offered
- upd_ready  out  1  FIFO can accept an update
- upd_index  in  IDX_W  entry to update
- upd_pc  in  TGT_W  branch PC (tag)
- upd_target  in  TGT_W  resolved target
- upd_taken  in  1  actual outcome
- upd_alloc  in  1  entry tag mismatched; allocate fresh
- tbl_en  out  1  table port enable
- tbl_we  out  1  table write enable
- tbl_addr  out  IDX_W  table address
- tbl_wdata  out  2*TGT_W+2  {tag, target, ctr}
- tbl_rdata_ctr  in  2  counter read data, valid the cycle after a read
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async on rst_n low): FIFO emptied, FSM to IDLE, capture register cleared. Outputs during and after reset until the next request:
  - tbl_en, tbl_we, lk_gnt, busy = 0
  - tbl_addr = 0, tbl_wdata = 0
  - upd_ready = 1 after reset; 0 while rst_n is low
- Reset mid-operation drops any in-flight RMW and all queued updates.
- Enqueue: accepted when upd_valid && upd_ready at a clk edge. upd_ready = !full.
- Port mux (combinational): if lk_req && !force, then lk_gnt=1, tbl_en=1, tbl_we=0, tbl_addr=lk_index. Otherwise the FSM drives the port.
- FSM states: IDLE, RD, CAP, WR.
  - IDLE, FIFO non-empty: head.alloc goes to WR; otherwise goes to RD.
  - RD: needs the port; drives read of head.index. Stays in RD while preempted; goes to CAP when it owns the port.
  - CAP: does not use the port. Latches tbl_rdata_ctr into ctr_q, then goes to WR. It cannot be preempted.
  - WR: needs the port; writes {head.pc, head.target, new_ctr} to head.index. Stays in WR while preempted. When it owns the port, pops the FIFO and returns to IDLE.
- new_ctr:
  - alloc: taken ? 2'b10 : 2'b01.
  - else taken: min(ctr_q+1, 3).
  - else not-taken: max(ctr_q-1, 0). No wrap.
- Latency: an uncontended non-alloc update completes its write 3 cycles after leaving IDLE; an alloc update completes in 1.
- Ordering: updates retire strictly in FIFO order, including repeated updates to the same index. There is no lookup forwarding from the FIFO.
- Simultaneous enqueue and pop in one cycle is legal; count is unchanged.
- FIFO pointers wrap modulo QDEPTH. full/empty are derived from a count of width log2(QDEPTH)+1.

Optional Feature:
- Macro: BHT_STARVE_GUARD_EN.
- With the macro: a counter increments each cycle the FSM is in RD/WR and preempted by lk_req. When it reaches STARVE_LIM, force=1 for one cycle: the FSM takes the port and lk_gnt=0 that cycle. The counter clears on any FSM port ownership or on reset.
- Without the macro: force is tied to 0, and lookups can starve updates indefinitely.

Decomposition:
- Shared package bht_pkg holds:
  - ctr_t (2-bit)
  - state enum {IDLE, RD, CAP, WR}
  - counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3
  - update-record struct {index, pc, target, taken, alloc}
- One sub-module: bht_upd_fifo, a parameterised synchronous FIFO of update records with count, full and empty.

Test Plan:
- Reset, then one update {idx=3, taken=1, alloc=0} with tbl_rdata_ctr=1 and no lookups. Expect: read of addr 3 at cycle 1, write ctr=2 to addr 3 at cycle 3, busy falls next cycle.
- Alloc update {idx=5, pc=0x40, target=0x80, taken=0}. Expect: single write of wdata {0x40, 0x80, 2'b01}, no read cycle.
- Saturation, both on index 2:
  - rdata=3 with taken=1: writes 3.
  - rdata=0 with taken=0: writes 0.
- Fill FIFO with 4 updates while lk_req is held high. Expect: upd_ready=0, the 5th offer is not accepted, lk_gnt=1 every cycle. After lk_req drops, all 4 retire in order.
- Assert rst_n=0 while in CAP with 2 entries queued. Expect: immediate tbl_en=0 and busy=0, no write after release.
- With BHT_STARVE_GUARD_EN and STARVE_LIM=8, hold lk_req continuously with one queued non-alloc update. Expect: forced read at the 8th blocked cycle (lk_gnt=0 that cycle), and a forced write 8 blocked cycles after CAP.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared types for the BHT update controller: counter encoding, FSM states and update records.
package bht_pkg;

  localparam int BHT_IDX_W = 3;
  localparam int BHT_TGT_W = 32;

  typedef logic [1:0] ctr_t;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] index;
    logic [BHT_TGT_W-1:0] pc;
    logic [BHT_TGT_W-1:0] target;
    logic                 taken;
    logic                 alloc;
  } upd_rec_t;

  // Fresh entries start weak in the observed direction; trained entries saturate, never wrap.
  function automatic ctr_t nextCtr(input ctr_t cur, input logic taken, input logic alloc);
    if (alloc) return taken ? CTR_WT : CTR_WNT;
    if (taken) return (cur == CTR_ST) ? CTR_ST : cur + 2'd1;
    return (cur == CTR_SNT) ? CTR_SNT : cur - 2'd1;
  endfunction

endpackage

// File: rtl/bht_update_ctrl_fifo.sv
// bht_upd_fifo: synchronous FIFO of BHT update records with occupancy count, full and empty.
module bht_upd_fifo
  import bht_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  upd_rec_t                 i_data,
  input  logic                     i_pop,
  output upd_rec_t                 o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  upd_rec_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT port arbiter: lookups win the single table port, queued updates retire as read-modify-write.
// Optional macro BHT_STARVE_GUARD_EN forces an update through after STARVE_LIM blocked cycles.
module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter int IDX_W      = BHT_IDX_W,
  parameter int QDEPTH     = 4,
  parameter int TGT_W      = BHT_TGT_W
`ifdef BHT_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIM = 8
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lk_req,
  input  logic [IDX_W-1:0]   lk_index,
  output logic               lk_gnt,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [IDX_W-1:0]   upd_index,
  input  logic [TGT_W-1:0]   upd_pc,
  input  logic [TGT_W-1:0]   upd_target,
  input  logic               upd_taken,
  input  logic               upd_alloc,
  output logic               tbl_en,
  output logic               tbl_we,
  output logic [IDX_W-1:0]   tbl_addr,
  output logic [2*TGT_W+1:0] tbl_wdata,
  input  logic [1:0]         tbl_rdata_ctr,
  output logic               busy
);

  state_t                  r_state;
  logic                    r_portReq;
  logic                    r_portWe;
  ctr_t                    r_ctrQ;
  upd_rec_t                w_head;
  upd_rec_t                w_updRec;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(QDEPTH):0] w_count;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_force;
  logic                    w_lkGnt;
  logic                    w_fsmOwns;
  ctr_t                    w_newCtr;

  assign w_updRec = '{index: upd_index, pc: upd_pc, target: upd_target,
                      taken: upd_taken, alloc: upd_alloc};
  assign upd_ready = rst_n && !w_full;
  assign w_push    = upd_valid && upd_ready;
  assign w_pop     = (r_state == WR) && w_fsmOwns;

  bht_upd_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_updRec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef BHT_STARVE_GUARD_EN
  localparam int SCNT_W = $clog2(STARVE_LIM + 1);
  logic [SCNT_W-1:0] r_starveCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_starveCnt <= '0;
    else if (w_fsmOwns)            r_starveCnt <= '0;
    else if (r_portReq && lk_req)  r_starveCnt <= r_starveCnt + 1'b1;
  end

  assign w_force = r_portReq && lk_req && (r_starveCnt == SCNT_W'(STARVE_LIM - 1));
`else
  assign w_force = 1'b0;
`endif

  assign w_lkGnt   = lk_req && !w_force;
  assign w_fsmOwns = r_portReq && !w_lkGnt;
  assign w_newCtr  = nextCtr(r_ctrQ, w_head.taken, w_head.alloc);

  assign lk_gnt    = w_lkGnt;
  assign tbl_en    = w_lkGnt || r_portReq;
  assign tbl_we    = !w_lkGnt && r_portWe;
  assign tbl_addr  = w_lkGnt ? lk_index : (r_portReq ? w_head.index : '0);
  assign tbl_wdata = (r_portWe && !w_lkGnt) ? {w_head.pc, w_head.target, w_newCtr} : '0;
  assign busy      = (w_count != '0) || (r_state != IDLE);

  // r_portReq/r_portWe are the registered port requests; the head record stays put until WR pops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_portReq <= 1'b0;
      r_portWe  <= 1'b0;
      r_ctrQ    <= CTR_SNT;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_portReq <= 1'b1;
            r_portWe  <= w_head.alloc;
            r_state   <= w_head.alloc ? WR : RD;
          end
        end
        RD: begin
          if (w_fsmOwns) begin
            r_portReq <= 1'b0;
            r_state   <= CAP;
          end
        end
        CAP: begin
          r_ctrQ    <= tbl_rdata_ctr;
          r_portReq <= 1'b1;
          r_portWe  <= 1'b1;
          r_state   <= WR;
        end
        WR: begin
          if (w_fsmOwns) begin
            r_portReq <= 1'b0;
            r_portWe  <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl: table of single updates, then fill/ordering and mid-RMW reset sequences.
module tb_bht_update_ctrl;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        alloc;
    logic [1:0]  initCtr;
    logic [1:0]  expCtr;
    int          expLat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        lk_req;
  logic [2:0]  lk_index;
  logic        lk_gnt;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_index;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_alloc;
  logic        tbl_en;
  logic        tbl_we;
  logic [2:0]  tbl_addr;
  logic [65:0] tbl_wdata;
  logic [1:0]  tbl_rdata_ctr;
  logic        busy;

  logic        preEn;
  logic [2:0]  preIdx;
  logic [1:0]  preVal;
  logic [1:0]  ctrMem [8];
  int          cyc = 0;

  logic [2:0]  wrAddrQ [$];
  logic [65:0] wrDataQ [$];
  int          wrCycQ  [$];
  logic [2:0]  rdAddrQ [$];
  int          rdCycQ  [$];

  int vecCount  = 0;
  int missCount = 0;

  vec_t vecs [8];
  vec_t fillVecs [4];
  vec_t extraVec;
  vec_t midVecs [3];

  bht_update_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lk_req        (lk_req),
    .lk_index      (lk_index),
    .lk_gnt        (lk_gnt),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_index     (upd_index),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .upd_alloc     (upd_alloc),
    .tbl_en        (tbl_en),
    .tbl_we        (tbl_we),
    .tbl_addr      (tbl_addr),
    .tbl_wdata     (tbl_wdata),
    .tbl_rdata_ctr (tbl_rdata_ctr),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counter storage model: read data appears the cycle after a read, writes land at the edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preEn) ctrMem[preIdx] <= preVal;
    else if (tbl_en && tbl_we) ctrMem[tbl_addr] <= tbl_wdata[1:0];
    if (tbl_en && !tbl_we) tbl_rdata_ctr <= ctrMem[tbl_addr];
  end

  always @(negedge clk) begin
    if (tbl_en && tbl_we) begin
      wrAddrQ.push_back(tbl_addr);
      wrDataQ.push_back(tbl_wdata);
      wrCycQ.push_back(cyc);
    end
    if (tbl_en && !tbl_we && !lk_gnt) begin
      rdAddrQ.push_back(tbl_addr);
      rdCycQ.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [65:0] actual, input logic [65:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic preload(input logic [2:0] idx, input logic [1:0] val);
    preEn  = 1'b1;
    preIdx = idx;
    preVal = val;
    tick();
    preEn  = 1'b0;
  endtask

  // Offers one update for one cycle; t0 is the first cycle the entry sits in the FIFO.
  task automatic applyStimulus(input vec_t vec, output bit accepted, output int t0);
    accepted   = upd_ready;
    upd_valid  = 1'b1;
    upd_index  = vec.idx;
    upd_pc     = vec.pc;
    upd_target = vec.target;
    upd_taken  = vec.taken;
    upd_alloc  = vec.alloc;
    tick();
    upd_valid  = 1'b0;
    t0         = cyc;
  endtask

  task automatic waitWrites(input int n, input int limit, output bit ok);
    for (int i = 0; i < limit; i++) begin
      if (wrAddrQ.size() >= n) break;
      tick();
    end
    ok = (wrAddrQ.size() >= n);
  endtask

  initial begin
    bit acc;
    bit ok;
    int t0;
    int nW;
    int nR;
    int fillRej;
    int gntCycles;

    vecs[0] = '{3'd3, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 2'd1, 2'd2, 3};
    vecs[1] = '{3'd5, 32'h0000_0040, 32'h0000_0080, 1'b0, 1'b1, 2'd3, 2'd1, 1};
    vecs[2] = '{3'd2, 32'h0000_0300, 32'h0000_0310, 1'b1, 1'b0, 2'd3, 2'd3, 3};
    vecs[3] = '{3'd2, 32'h0000_0320, 32'h0000_0330, 1'b0, 1'b0, 2'd0, 2'd0, 3};
    vecs[4] = '{3'd7, 32'hDEAD_BEEC, 32'h1234_5678, 1'b0, 1'b0, 2'd2, 2'd1, 3};
    vecs[5] = '{3'd0, 32'hA5A5_0000, 32'h5A5A_FFFC, 1'b1, 1'b1, 2'd0, 2'd2, 1};
    vecs[6] = '{3'd4, 32'h0000_0400, 32'h0000_0440, 1'b1, 1'b0, 2'd2, 2'd3, 3};
    vecs[7] = '{3'd6, 32'h0000_0600, 32'h0000_0660, 1'b0, 1'b0, 2'd3, 2'd2, 3};

    fillVecs[0] = '{3'd1, 32'h0000_1000, 32'h0000_1004, 1'b1, 1'b0, 2'd0, 2'd1, 0};
    fillVecs[1] = '{3'd1, 32'h0000_1010, 32'h0000_1014, 1'b1, 1'b0, 2'd0, 2'd2, 0};
    fillVecs[2] = '{3'd6, 32'h0000_1020, 32'h0000_1024, 1'b1, 1'b1, 2'd0, 2'd2, 0};
    fillVecs[3] = '{3'd1, 32'h0000_1030, 32'h0000_1034, 1'b0, 1'b0, 2'd0, 2'd1, 0};
    extraVec    = '{3'd7, 32'h0000_1040, 32'h0000_1044, 1'b1, 1'b1, 2'd0, 2'd2, 0};

    midVecs[0] = '{3'd4, 32'h0000_2000, 32'h0000_2004, 1'b1, 1'b0, 2'd0, 2'd0, 0};
    midVecs[1] = '{3'd5, 32'h0000_2010, 32'h0000_2014, 1'b1, 1'b0, 2'd0, 2'd0, 0};
    midVecs[2] = '{3'd6, 32'h0000_2020, 32'h0000_2024, 1'b1, 1'b0, 2'd0, 2'd0, 0};

    rst_n      = 1'b0;
    lk_req     = 1'b0;
    lk_index   = 3'd0;
    upd_valid  = 1'b0;
    upd_index  = 3'd0;
    upd_pc     = 32'd0;
    upd_target = 32'd0;
    upd_taken  = 1'b0;
    upd_alloc  = 1'b0;
    preEn      = 1'b0;
    preIdx     = 3'd0;
    preVal     = 2'd0;

    tick();
    checkOutput("rstTblEn", tbl_en, 0);
    checkOutput("rstTblWe", tbl_we, 0);
    checkOutput("rstLkGnt", lk_gnt, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstAddr", tbl_addr, 0);
    checkOutput("rstWdata", tbl_wdata, 0);
    checkOutput("rstReadyLow", upd_ready, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("postRstReady", upd_ready, 1);
    checkOutput("postRstTblEn", tbl_en, 0);

    $display("[TB] single-update vector table");
    for (int v = 0; v < 8; v++) begin
      preload(vecs[v].idx, vecs[v].initCtr);
      nW = wrAddrQ.size();
      nR = rdAddrQ.size();
      applyStimulus(vecs[v], acc, t0);
      checkOutput("vecAccepted", acc, 1);
      waitWrites(nW + 1, 20, ok);
      checkOutput("vecWriteSeen", ok, 1);
      if (ok) begin
        checkOutput("vecLatency", wrCycQ[nW] - t0, vecs[v].expLat);
        checkOutput("vecWrAddr", wrAddrQ[nW], vecs[v].idx);
        checkOutput("vecWrData", wrDataQ[nW], {vecs[v].pc, vecs[v].target, vecs[v].expCtr});
        checkOutput("vecReadCount", rdAddrQ.size() - nR, vecs[v].alloc ? 0 : 1);
        if (!vecs[v].alloc && rdAddrQ.size() > nR) begin
          checkOutput("vecRdAddr", rdAddrQ[nR], vecs[v].idx);
          checkOutput("vecRdCycle", rdCycQ[nR] - t0, 1);
        end
      end
      tick();
      checkOutput("vecBusyFall", busy, 0);
    end

    $display("[TB] fill FIFO under continuous lookups");
    preload(3'd1, 2'd0);
    nW = wrAddrQ.size();
    lk_req   = 1'b1;
    lk_index = 3'd5;
    tick();
    checkOutput("fillLkGnt", lk_gnt, 1);
    fillRej = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(fillVecs[i], acc, t0);
      if (!acc) fillRej++;
    end
    checkOutput("fillAllAccepted", fillRej, 0);
    checkOutput("fillReadyLow", upd_ready, 0);
    applyStimulus(extraVec, acc, t0);
    checkOutput("fillFifthRejected", acc, 0);
    gntCycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (lk_gnt && tbl_en && !tbl_we && tbl_addr == 3'd5) gntCycles++;
      tick();
    end
    checkOutput("fillLkGntHeld", gntCycles, 5);
    checkOutput("fillNoWriteBlocked", wrAddrQ.size() - nW, 0);
    checkOutput("fillBusy", busy, 1);
    lk_req = 1'b0;
    waitWrites(nW + 4, 40, ok);
    checkOutput("fillDrained", ok, 1);
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("fillOrderAddr", wrAddrQ[nW + k], fillVecs[k].idx);
        checkOutput("fillOrderData", wrDataQ[nW + k],
                    {fillVecs[k].pc, fillVecs[k].target, fillVecs[k].expCtr});
      end
    end
    repeat (10) tick();
    checkOutput("fillNoExtraWrite", wrAddrQ.size() - nW, 4);
    checkOutput("fillIdleBusy", busy, 0);

    $display("[TB] reset during CAP with two entries queued");
    nW = wrAddrQ.size();
    nR = rdAddrQ.size();
    for (int i = 0; i < 3; i++) applyStimulus(midVecs[i], acc, t0);
    checkOutput("midReadIssued", rdAddrQ.size() - nR, 1);
    checkOutput("midNoWriteYet", wrAddrQ.size() - nW, 0);
    checkOutput("midBusyBefore", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstTblEn", tbl_en, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstReady", upd_ready, 0);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    checkOutput("midNoWriteAfter", wrAddrQ.size() - nW, 0);
    checkOutput("midBusyAfter", busy, 0);
    checkOutput("midReadyAfter", upd_ready, 1);

`ifdef BHT_STARVE_GUARD_EN
    $display("[TB] starvation guard under continuous lookups");
    preload(3'd3, 2'd1);
    nW = wrAddrQ.size();
    nR = rdAddrQ.size();
    lk_req   = 1'b1;
    lk_index = 3'd0;
    applyStimulus(vecs[0], acc, t0);
    waitWrites(nW + 1, 40, ok);
    checkOutput("starveWriteSeen", ok, 1);
    if (ok && rdAddrQ.size() > nR) begin
      checkOutput("starveRdCycle", rdCycQ[nR] - t0, 8);
      checkOutput("starveWrCycle", wrCycQ[nW] - t0, 17);
      checkOutput("starveWrData", wrDataQ[nW], {vecs[0].pc, vecs[0].target, 2'd2});
    end
    lk_req = 1'b0;
    repeat (3) tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
